// File: rtl/cpu_mem_pkg.sv
// Shared memory-port definitions: FSM states, owner encoding, widths.
// Used by mem_port_arbiter and mem_lat_timer.
package cpu_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int INST_W = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_I = 2'd1;
  localparam logic [1:0] ST_GNT_D = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GNT_I = ST_GNT_I,
    GNT_D = ST_GNT_D,
    WAIT  = ST_WAIT
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_lat_timer.sv
// 4-bit memory latency timer: load on grant, count down, flag zero.
// Instantiated by mem_port_arbiter.
module mem_lat_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);
  import cpu_mem_pkg::*;

  logic [3:0] cnt;

  // Load takes priority; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// IF/MEM arbiter for a single-port unified memory, data-over-fetch priority
// with starvation guard. Optional ARB_PERF_CNT_EN adds wait-cycle counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W     = cpu_mem_pkg::DATA_W,
  parameter int INST_W     = cpu_mem_pkg::INST_W,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [INST_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_d_wait
`endif
);
  import cpu_mem_pkg::*;

  localparam logic [3:0] LAT        = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_e  state, state_nxt;
  logic        owner_q;
  logic        we_q;
  logic        hi_q;
  logic [3:0]  starve_cnt;
  logic        d_win, i_win, grant, done, lat_zero;
  logic        if_valid_q, d_valid_q;
  logic [INST_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Arbitration inputs: data wins unless the fetch has been starved.
  always_comb begin
    d_win = d_req & ~(if_req & (starve_cnt == STARVE_LIM));
    i_win = ~d_win & if_req;
    grant = (state == IDLE) & (d_win | i_win);
    done  = (state == WAIT) & lat_zero;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (d_win)      state_nxt = GNT_D;
        else if (i_win) state_nxt = GNT_I;
      end
      GNT_I, GNT_D: state_nxt = WAIT;
      WAIT: if (lat_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  mem_lat_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (grant),
    .load_val (LAT),
    .dec      (state != IDLE),
    .zero     (lat_zero)
  );

  // Latch the granted request; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_I;
      we_q    <= 1'b0;
      hi_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner_q <= d_win ? OWN_D : OWN_I;
      we_q    <= d_win & d_we;
      hi_q    <= if_addr[2];
      addr_q  <= d_win ? d_addr : if_addr;
      if (d_win) wdata_q <= d_wdata;
    end
  end

  // Starvation counter: D grants while a fetch waits; cleared by I grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (grant) begin
      if (!d_win)
        starve_cnt <= 4'd0;
      else if (if_req && starve_cnt < STARVE_LIM)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Capture read data at completion and pulse the owner's valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_valid_q <= done & (owner_q == OWN_I);
      d_valid_q  <= done & (owner_q == OWN_D);
      if (done && owner_q == OWN_I)
        if_rdata_q <= hi_q ? mem_rdata[DATA_W-1 -: INST_W]
                           : mem_rdata[INST_W-1:0];
      if (done && owner_q == OWN_D && !we_q)
        d_rdata_q <= mem_rdata;
    end
  end

  assign mem_en    = (state == GNT_I) | (state == GNT_D);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign stall     = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

`ifdef ARB_PERF_CNT_EN
  // Wait-cycle counters; wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_wait <= 32'd0;
      perf_d_wait  <= 32'd0;
    end else begin
      if (if_req & ~if_valid_q) perf_if_wait <= perf_if_wait + 32'd1;
      if (d_req & ~d_valid_q)   perf_d_wait  <= perf_d_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a 2-cycle memory model.
// Perf-counter checks run only when ARB_PERF_CNT_EN is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_valid;
  logic [63:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        stall;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait;
  logic [31:0] perf_d_wait;
`endif

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall     (stall)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_wait (perf_if_wait),
    .perf_d_wait  (perf_d_wait)
`endif
  );

  always #5 clk = ~clk;

  int cyc  = 0;
  int gcnt = 0;
  int n_chk = 0;
  int n_err = 0;
  logic        mem_init;
  logic [63:0] mem [0:31];
  logic [63:0] p0, p1;
  logic        glog [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: reads return 2 cycles after mem_en.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 64'h0;
      mem[0] <= 64'hAAAA_BBBB_CCCC_DDDD;
      mem[3] <= 64'h0000_0000_0000_0D03;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:3]] <= mem_wdata;
      p0 <= mem[mem_addr[7:3]];
    end
    p1 <= p0;
  end
  assign mem_rdata = p1;

  // Grant log: 1 = data port (address 0x18 in the starvation test).
  always @(posedge clk) begin
    if (mem_en) begin
      glog[gcnt[7:0]] <= (mem_addr == 32'h18);
      gcnt <= gcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input logic is_d, input logic we,
                        input logic [31:0] addr, input logic [63:0] wd,
                        output int t, output int en_c, output int v_c,
                        output logic [63:0] rd, output int n_en,
                        output logic we_s, output logic [31:0] addr_s);
    @(posedge clk);
    #1;
    t = cyc; en_c = -1; v_c = -1; rd = '0;
    n_en = 0; we_s = 1'b0; addr_s = '0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_en) begin
        n_en++;
        if (en_c < 0) en_c = cyc;
        we_s = mem_we; addr_s = mem_addr;
      end
      if (is_d ? d_valid : if_valid) begin
        v_c = cyc;
        rd = is_d ? d_rdata : {32'h0, if_rdata};
        break;
      end
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  int t, en_c, v_c, n_en, nlow, nval, dv, iv, en1, en2;
  logic [63:0] rd;
  logic we_s, we1;
  logic [31:0] addr_s, addr2;
  int gbase;
  logic [7:0] pat;

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_stall", stall, 0);
    if_req = 1'b1;
    #1 chk("rst_stall_eq", stall, 1);
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single fetch of upper half.
    do_req(0, 0, 32'h4, 0, t, en_c, v_c, rd, n_en, we_s, addr_s);
    chk("f_en_cyc", en_c, t + 1);
    chk("f_valid_cyc", v_c, t + 4);
    chk("f_rdata", rd, 64'hAAAA_BBBB);
    chk("f_we", we_s, 0);

    // Load, then store must leave d_rdata alone.
    do_req(1, 0, 32'h0, 0, t, en_c, v_c, rd, n_en, we_s, addr_s);
    chk("ld_valid_cyc", v_c, t + 4);
    chk("ld_rdata", rd, 64'hAAAA_BBBB_CCCC_DDDD);
    do_req(1, 1, 32'h10, 64'h1234, t, en_c, v_c, rd, n_en, we_s, addr_s);
    chk("st_n_en", n_en, 1);
    chk("st_we", we_s, 1);
    chk("st_addr", addr_s, 32'h10);
    chk("st_valid_cyc", v_c, t + 4);
    chk("st_rdata_kept", d_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    do_req(1, 0, 32'h10, 0, t, en_c, v_c, rd, n_en, we_s, addr_s);
    chk("ld_after_st", rd, 64'h1234);

    // Both requesters held: D,D,D,I,D,D,D,I.
    do_reset();
    @(posedge clk);
    #1;
    gbase = gcnt; nlow = 0;
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h18;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!stall) nlow++;
      if (gcnt - gbase >= 8) break;
    end
    if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 8; i++) pat[i] = glog[(gbase + i) % 256];
    chk("starve_order", pat, 8'b0111_0111);
    chk("starve_stall", nlow, 0);
    repeat (8) @(negedge clk);

    // Reset during WAIT of a load.
    do_reset();
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_en) break;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstw_mem_en", mem_en, 0);
    d_req = 1'b0;
    nval = 0; n_en = 0;
    repeat (2) begin
      @(negedge clk);
      if (d_valid) nval++;
      if (mem_en) n_en++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (d_valid) nval++;
      if (mem_en) n_en++;
    end
    chk("rstw_no_valid", nval, 0);
    chk("rstw_no_en", n_en, 0);
    do_req(1, 0, 32'h10, 0, t, en_c, v_c, rd, n_en, we_s, addr_s);
    chk("rstw_reload_cyc", v_c, t + 4);
    chk("rstw_reload", rd, 64'h1234);

    // Store whose d_req drops after grant; fetch follows.
    do_reset();
    @(posedge clk);
    #1;
    t = cyc; dv = -1; iv = -1; en1 = -1; en2 = -1;
    we1 = 0; addr2 = 0; rd = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 64'h5555;
    if_req = 1'b1; if_addr = 32'h10;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_en && en1 < 0) begin
        en1 = cyc; we1 = mem_we;
      end else if (mem_en && en2 < 0) begin
        en2 = cyc; addr2 = mem_addr;
      end
      if (cyc == t + 2) begin
        d_req = 1'b0; d_we = 1'b0;
      end
      if (d_valid && dv < 0) dv = cyc;
      if (if_valid) begin
        iv = cyc; rd = {32'h0, if_rdata};
        break;
      end
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    chk("drop_en1", en1, t + 1);
    chk("drop_we1", we1, 1);
    chk("drop_dvalid", dv, t + 4);
    chk("drop_en2", en2, t + 5);
    chk("drop_addr2", addr2, 32'h10);
    chk("drop_ivalid", iv, t + 8);
    chk("drop_irdata", rd, 64'h1234);
    chk("drop_mem_wr", mem[4], 64'h5555);

`ifdef ARB_PERF_CNT_EN
    // Fetch waits behind a load: 7 blocked cycles.
    do_reset();
    chk("perf_rst_if", perf_if_wait, 0);
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h0;
    iv = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_valid) d_req = 1'b0;
      if (if_valid) begin
        iv = cyc;
        if_req = 1'b0;
        break;
      end
    end
    @(negedge clk);
    chk("perf_if_wait", perf_if_wait, 7);
    chk("perf_d_wait", perf_d_wait, 4);
    do_reset();
    chk("perf_clr_if", perf_if_wait, 0);
    chk("perf_clr_d", perf_d_wait, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
